item_ram_arbiter: RTL and testbench

- Shares the single item RAM between N requesters: player-0 rope, player-1 rope, and the item renderer.
- Each requester uses the req/done handshake the rope controllers already use: read_req/write_req, address, write_data, read_done/write_done.
- Grants are round-robin, one transaction at a time. The block drives the RAM port directly.
- Optional lock keeps stone pick-up (read, modify, write) atomic across both players.

---
 rtl/item_ram_pkg.sv | 30 +++
 rtl/rr_pick.sv | 25 ++
 rtl/item_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_item_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/item_ram_pkg.sv
// Shared definitions for the item RAM arbiter: FSM states, item record layout, requester ids.
// S_HOLD only exists when ARB_LOCK_EN is defined.
package item_ram_pkg;

    localparam int REQ_P0   = 0;
    localparam int REQ_P1   = 1;
    localparam int REQ_DRAW = 2;

    // Item record field positions inside the 32-bit RAM word
    localparam int ITEM_X_MSB       = 31;
    localparam int ITEM_X_LSB       = 23;
    localparam int ITEM_Y_MSB       = 18;
    localparam int ITEM_Y_LSB       = 11;
    localparam int ITEM_TYPE_MSB    = 3;
    localparam int ITEM_TYPE_LSB    = 2;
    localparam int ITEM_VISIBLE_BIT = 1;
    localparam int ITEM_MOVING_BIT  = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
`ifdef ARB_LOCK_EN
        , S_HOLD = 3'd5
`endif
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first active requester at or after the pointer, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [IDX_W-1:0]   pointer,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(pointer) + k) % NUM_REQ);
            if (!valid && active[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/item_ram_arbiter.sv
// Round-robin arbiter sharing the item RAM between both rope controllers and the renderer.
// Define ARB_LOCK_EN to let an owner keep the grant across a read-modify-write.
module item_ram_arbiter
    import item_ram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        read_done,
    output logic [NUM_REQ-1:0]        write_done,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      ram_wren,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      busy,
    output logic [1:0]                grant_id
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [1:0] LAST_ID  = 2'(NUM_REQ - 1);

    arb_state_t           state, state_next;
    logic [1:0]           pointer;
    logic [1:0]           lat_cnt;
    logic                 is_write;
    logic [NUM_REQ-1:0]   active;
    logic [1:0]           pick_winner;
    logic                 pick_valid;
    logic                 take_grant;
    logic                 take_hold;
    logic [1:0]           sel_id;
    logic [NUM_REQ-1:0]   done_vec;

    assign active = req_read | req_write;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(2)) u_pick (
        .active (active),
        .pointer(pointer),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        take_hold  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    take_grant = 1'b1;
                    state_next = req_write[pick_winner] ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_next = S_DONE;
            S_READ: begin
                if (lat_cnt == LAT_LAST) state_next = S_DONE;
            end
`ifdef ARB_LOCK_EN
            S_DONE: state_next = req_lock[grant_id] ? S_HOLD : S_GAP;
            // Only the lock owner is served here; the pointer stays put
            S_HOLD: begin
                if (active[grant_id]) begin
                    take_hold  = 1'b1;
                    state_next = req_write[grant_id] ? S_WRITE : S_READ;
                end else if (!req_lock[grant_id]) begin
                    state_next = S_GAP;
                end
            end
`else
            S_DONE: state_next = S_GAP;
`endif
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sel_id     = take_hold ? grant_id : pick_winner;
        done_vec   = NUM_REQ'(1) << grant_id;
        read_done  = '0;
        write_done = '0;
        if (state == S_DONE) begin
            if (is_write) write_done = done_vec;
            else          read_done  = done_vec;
        end
        ram_wren = (state == S_WRITE);
        busy     = (state != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            pointer   <= '0;
            lat_cnt   <= '0;
            is_write  <= 1'b0;
            grant_id  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_data   <= '0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                grant_id <= pick_winner;
                pointer  <= (pick_winner == LAST_ID) ? 2'd0 : pick_winner + 2'd1;
            end
            if (take_grant || take_hold) begin
                ram_addr  <= req_addr[sel_id*ADDR_W +: ADDR_W];
                ram_wdata <= req_wdata[sel_id*DATA_W +: DATA_W];
                is_write  <= req_write[sel_id];
                lat_cnt   <= '0;
            end else if (state == S_READ) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            // ram_addr has been stable for RD_LAT cycles by the last read cycle
            if (state == S_READ && lat_cnt == LAT_LAST) rd_data <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_item_ram_arbiter.sv
// Testbench for item_ram_arbiter: directed scenarios plus random rounds against a schedule model.
// Expectations for the lock scenario follow ARB_LOCK_EN.
module tb_item_ram_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int RD_LAT  = 1;
    localparam int LAT_RD  = RD_LAT + 1;
    localparam int LAT_WR  = 2;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_read = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        req_lock = '0;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        read_done;
    logic [NUM_REQ-1:0]        write_done;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_wdata;
    logic                      ram_wren;
    logic [DATA_W-1:0]         ram_rdata;
    logic                      busy;
    logic [1:0]                grant_id;

    logic [DATA_W-1:0] ram_mem   [16];
    logic [DATA_W-1:0] model_mem [16];
    logic [ADDR_W-1:0] t_addr [NUM_REQ];
    logic [DATA_W-1:0] t_data [NUM_REQ];
    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    item_ram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
        .rd_data(rd_data), .read_done(read_done), .write_done(write_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_rdata(ram_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clock) if (ram_wren) ram_mem[ram_addr] <= ram_wdata;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr, input logic [2:0] lk);
        req_read  = rd;
        req_write = wr;
        req_lock  = lk;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = t_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = t_data[i];
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_ptr = 0;
    endtask

    // Predict grant order and done cycles from round-robin rules, then watch the DUT cycle by cycle
    task automatic runRound(input string tag, input logic [2:0] rd, input logic [2:0] wr, input bit early_drop);
        int who_q[$];
        bit wr_q[$];
        int done_q[$];
        logic [2:0] prd, pwr, cur_rd, cur_wr;
        logic [2:0] exp_rdone, exp_wdone;
        logic exp_wren, exp_busy;
        logic [ADDR_W-1:0] exp_waddr;
        logic [DATA_W-1:0] exp_wdata;
        int ptr, t, w, lat, last;
        bit isw;
        prd = rd; pwr = wr; ptr = model_ptr; t = 0;
        while ((prd | pwr) != 3'b000) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (ptr + k) % NUM_REQ;
                if (w < 0 && (prd[c] || pwr[c])) w = c;
            end
            isw = pwr[w];
            t = t + (isw ? LAT_WR : LAT_RD);
            who_q.push_back(w); wr_q.push_back(isw); done_q.push_back(t);
            if (isw) pwr[w] = 1'b0; else prd[w] = 1'b0;
            t = t + 2;
            ptr = (w + 1) % NUM_REQ;
        end
        last = done_q[done_q.size()-1];
        cur_rd = rd; cur_wr = wr;
        applyStimulus(cur_rd, cur_wr, 3'b000);
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clock);
            exp_rdone = '0; exp_wdone = '0; exp_wren = 1'b0; exp_busy = 1'b0;
            exp_waddr = '0; exp_wdata = '0;
            for (int j = 0; j < who_q.size(); j++) begin
                lat = wr_q[j] ? LAT_WR : LAT_RD;
                if (k >= done_q[j] - lat + 1 && k <= done_q[j] + 1) exp_busy = 1'b1;
                if (done_q[j] == k) begin
                    if (wr_q[j]) exp_wdone[who_q[j]] = 1'b1;
                    else         exp_rdone[who_q[j]] = 1'b1;
                end
                if (wr_q[j] && done_q[j] - 1 == k) begin
                    exp_wren  = 1'b1;
                    exp_waddr = t_addr[who_q[j]];
                    exp_wdata = t_data[who_q[j]];
                end
            end
            checkOutput({tag, " read_done"}, 64'(read_done), 64'(exp_rdone));
            checkOutput({tag, " write_done"}, 64'(write_done), 64'(exp_wdone));
            checkOutput({tag, " ram_wren"}, 64'(ram_wren), 64'(exp_wren));
            checkOutput({tag, " busy"}, 64'(busy), 64'(exp_busy));
            if (exp_wren) begin
                checkOutput({tag, " ram_addr"}, 64'(ram_addr), 64'(exp_waddr));
                checkOutput({tag, " ram_wdata"}, 64'(ram_wdata), 64'(exp_wdata));
            end
            for (int j = 0; j < who_q.size(); j++) begin
                if (done_q[j] == k) begin
                    checkOutput({tag, " grant_id"}, 64'(grant_id), 64'(who_q[j]));
                    if (wr_q[j]) begin
                        model_mem[t_addr[who_q[j]]] = t_data[who_q[j]];
                        cur_wr[who_q[j]] = 1'b0;
                    end else begin
                        checkOutput({tag, " rd_data"}, 64'(rd_data), 64'(model_mem[t_addr[who_q[j]]]));
                        cur_rd[who_q[j]] = 1'b0;
                    end
                end
            end
            if (early_drop && k == 1) begin
                cur_rd[who_q[0]] = 1'b0;
                cur_wr[who_q[0]] = 1'b0;
            end
            applyStimulus(cur_rd, cur_wr, 3'b000);
        end
        model_ptr = ptr;
    endtask

    initial begin
        int seen_r0, seen_w0, seen_r1;
        int exp_r0, exp_w0, exp_r1;
        logic [2:0] cur_rd, cur_wr, lk;
        logic [2:0] rrd, rwr;
        logic [DATA_W-1:0] v;

        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            if (i == 5) v = 32'h1234_5002;
            ram_mem[i] <= v;
            model_mem[i] = v;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end

        // Reset values with requests asserted underneath
        @(negedge clock);
        applyStimulus(3'b111, 3'b010, 3'b000);
        @(negedge clock);
        checkOutput("reset rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset read_done", 64'(read_done), 64'd0);
        checkOutput("reset write_done", 64'(write_done), 64'd0);
        checkOutput("reset ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("reset ram_wdata", 64'(ram_wdata), 64'd0);
        checkOutput("reset ram_wren", 64'(ram_wren), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset grant_id", 64'(grant_id), 64'd0);
        doReset();

        t_addr[0] = 4'd5;
        runRound("single_read", 3'b001, 3'b000, 1'b0);
        checkOutput("single_read value", 64'(rd_data), 64'h1234_5002);

        t_addr[1] = 4'd2; t_data[1] = 32'hDEAD_0003;
        runRound("single_write", 3'b000, 3'b010, 1'b0);
        checkOutput("single_write ram", 64'(ram_mem[2]), 64'hDEAD_0003);

        doReset();
        t_addr[0] = 4'd1; t_addr[1] = 4'd2; t_addr[2] = 4'd5;
        t_data[0] = 32'hA0A0_0001; t_data[1] = 32'hB1B1_0002; t_data[2] = 32'hC2C2_0003;
        runRound("contention1", 3'b111, 3'b000, 1'b0);
        runRound("contention2", 3'b101, 3'b010, 1'b0);

        t_addr[2] = 4'd9; t_data[2] = 32'h5A5A_0009;
        runRound("rd_wr_same", 3'b100, 3'b100, 1'b0);

        t_addr[1] = 4'd2;
        runRound("early_drop", 3'b010, 3'b000, 1'b1);

        // Reset while the read is in flight
        t_addr[1] = 4'd7;
        applyStimulus(3'b010, 3'b000, 3'b000);
        @(negedge clock);
        checkOutput("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clock);
        checkOutput("abort read_done", 64'(read_done), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort grant_id", 64'(grant_id), 64'd0);
        checkOutput("abort ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("abort rd_data", 64'(rd_data), 64'd0);
        @(negedge clock);
        checkOutput("abort read_done2", 64'(read_done), 64'd0);
        reset = 1'b0;
        model_ptr = 0;
        runRound("after_abort", 3'b111, 3'b000, 1'b0);

        // Requester 0 reads then writes addr 3 under lock while requester 1 waits
        doReset();
        t_addr[0] = 4'd3; t_data[0] = 32'hC0DE_0001; t_addr[1] = 4'd7;
        cur_rd = 3'b011; cur_wr = 3'b000; lk = 3'b001;
        seen_r0 = -1; seen_w0 = -1; seen_r1 = -1;
        applyStimulus(cur_rd, cur_wr, lk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (read_done[0] && seen_r0 < 0) begin
                seen_r0 = k;
                checkOutput("lock rd_data0", 64'(rd_data), 64'(model_mem[3]));
                cur_rd[0] = 1'b0; cur_wr[0] = 1'b1;
            end
            if (write_done[0] && seen_w0 < 0) begin
                seen_w0 = k;
                model_mem[3] = t_data[0];
                cur_wr[0] = 1'b0; lk = 3'b000;
            end
            if (read_done[1] && seen_r1 < 0) begin
                seen_r1 = k;
                checkOutput("lock rd_data1", 64'(rd_data), 64'(model_mem[7]));
                cur_rd[1] = 1'b0;
            end
            applyStimulus(cur_rd, cur_wr, lk);
        end
        exp_r0 = LAT_RD;
`ifdef ARB_LOCK_EN
        exp_w0 = exp_r0 + 1 + LAT_WR;
        exp_r1 = exp_w0 + 2 + LAT_RD;
        model_ptr = 2;
`else
        exp_r1 = exp_r0 + 2 + LAT_RD;
        exp_w0 = exp_r1 + 2 + LAT_WR;
        model_ptr = 1;
`endif
        checkOutput("lock read0 cycle", 64'(seen_r0), 64'(exp_r0));
        checkOutput("lock write0 cycle", 64'(seen_w0), 64'(exp_w0));
        checkOutput("lock read1 cycle", 64'(seen_r1), 64'(exp_r1));
        checkOutput("lock ram3", 64'(ram_mem[3]), 64'hC0DE_0001);

        for (int r = 0; r < 8; r++) begin
            rrd = 3'($urandom_range(0, 7));
            rwr = 3'($urandom_range(0, 7));
            if ((rrd | rwr) == 3'b000) rrd = 3'b001;
            for (int i = 0; i < NUM_REQ; i++) begin
                t_addr[i] = 4'($urandom_range(0, 15));
                t_data[i] = $urandom;
            end
            runRound("random", rrd, rwr, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
